// File: rtl/mem_bus_master_pkg.sv
// Shared constants and FSM state encoding for the matrix-memory bus master.
// Default bus geometry: 8 entries x 256-bit words, 4-bit address, 3-bit burst length.
package mem_bus_master_pkg;

    localparam int unsigned MBM_DATA_W = 256;
    localparam int unsigned MBM_ADDR_W = 4;
    localparam int unsigned MBM_DEPTH  = 8;
    localparam int unsigned MBM_LEN_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ERR      = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_WR_DRIVE = 3'd3,
        S_RD_ADDR  = 3'd4,
        S_RD_DATA  = 3'd5,
        S_TURN     = 3'd6
    } state_e;

endpackage

// File: rtl/mem_bus_master_beat_counter.sv
// Burst address/beat tracker: loads start address and length, steps the
// address modulo DEPTH and flags the final beat of the burst.
module mem_beat_counter #(
    parameter int unsigned ADDR_W = mem_bus_master_pkg::MBM_ADDR_W,
    parameter int unsigned DEPTH  = mem_bus_master_pkg::MBM_DEPTH,
    parameter int unsigned LEN_W  = mem_bus_master_pkg::MBM_LEN_W
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        if (load_i) begin
            addr_d   = addr_i;
            remain_d = len_i;
        end else if (step_i) begin
            addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
            remain_d = remain_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (remain_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Bus initiator for the single-bus matrix memory: sequences nEnable/ReadWrite/
// address for load/store bursts and owns the tristate dataBus only while storing.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int unsigned DATA_W = MBM_DATA_W,
    parameter int unsigned ADDR_W = MBM_ADDR_W,
    parameter int unsigned DEPTH  = MBM_DEPTH,
    parameter int unsigned LEN_W  = MBM_LEN_W
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [LEN_W-1:0]  cmdLen,
    input  logic [DATA_W-1:0] wrData,
    input  logic              wrValid,
    output logic              wrReady,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              done,
    output logic              err,
    inout  wire  [DATA_W-1:0] dataBus,
    output logic [ADDR_W-1:0] address,
    output logic              nEnable,
    output logic              ReadWrite
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] drive_q, drive_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              cnt_load, cnt_step, cnt_last;
    logic [ADDR_W-1:0] cur_addr;
    logic              addr_bad;
    logic              bus_oe;

    assign addr_bad = ({1'b0, cmdAddr} >= (ADDR_W + 1)'(DEPTH));

    mem_beat_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) u_beat_counter (
        .clk    (clk),
        .nReset (nReset),
        .load_i (cnt_load),
        .addr_i (cmdAddr),
        .len_i  (cmdLen),
        .step_i (cnt_step),
        .addr_o (cur_addr),
        .last_o (cnt_last)
    );

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_step   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    cnt_load = 1'b1;
                    if (addr_bad)      state_d = S_ERR;
                    else if (cmdWrite) state_d = S_WR_WAIT;
                    else               state_d = S_RD_ADDR;
                end
            end
            S_ERR: state_d = S_IDLE;
            S_WR_WAIT: begin
                if (wrValid) begin
                    drive_d = wrData;
                    state_d = S_WR_DRIVE;
                end
            end
            S_WR_DRIVE: begin
                if (cnt_last) begin
                    state_d = S_TURN;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = S_WR_WAIT;
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: begin
                rd_data_d  = dataBus;
                rd_valid_d = 1'b1;
                if (cnt_last) begin
                    state_d = S_TURN;
                end else begin
                    cnt_step = 1'b1;
                    state_d  = S_RD_ADDR;
                end
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and handshake outputs decode from registered state only.
    always_comb begin
        nEnable   = 1'b1;
        ReadWrite = 1'b1;
        bus_oe    = 1'b0;
        cmdReady  = 1'b0;
        wrReady   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            S_IDLE:    cmdReady = 1'b1;
            S_ERR:     err      = 1'b1;
            S_WR_WAIT: wrReady  = 1'b1;
            S_WR_DRIVE: begin
                nEnable   = 1'b0;
                ReadWrite = 1'b0;
                bus_oe    = 1'b1;
            end
            S_RD_ADDR: nEnable = 1'b0;
            S_RD_DATA: begin
                nEnable   = 1'b0;
                ReadWrite = 1'b0;
            end
            S_TURN:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            drive_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drive_q    <= drive_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign address = cur_addr;
    assign rdData  = rd_data_q;
    assign rdValid = rd_valid_q;
    assign dataBus = bus_oe ? drive_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master with an 8x256 bus memory model on the shared dataBus;
// expected beats are queued at issue time and checked by a negedge monitor.
module tb_mem_bus_master;

    localparam int unsigned DW = 256;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic          cmdWrite = 1'b0;
    logic [3:0]    cmdAddr = '0;
    logic [2:0]    cmdLen = '0;
    logic [DW-1:0] wrData = '0;
    logic          wrValid = 1'b0;
    logic          wrReady;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          done;
    logic          err;
    wire  [DW-1:0] dataBus;
    logic [3:0]    address;
    logic          nEnable;
    logic          ReadWrite;

    always #5 clk = ~clk;

    mem_bus_master #(
        .DATA_W (256),
        .ADDR_W (4),
        .DEPTH  (8),
        .LEN_W  (3)
    ) dut (
        .clk       (clk),
        .nReset    (nReset),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdWrite  (cmdWrite),
        .cmdAddr   (cmdAddr),
        .cmdLen    (cmdLen),
        .wrData    (wrData),
        .wrValid   (wrValid),
        .wrReady   (wrReady),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .done      (done),
        .err       (err),
        .dataBus   (dataBus),
        .address   (address),
        .nEnable   (nEnable),
        .ReadWrite (ReadWrite)
    );

    // Memory model: latch entry on a read-phase rising edge, drive it during
    // the following data phase, write the bus back on the falling edge.
    logic [DW-1:0] mem [8];
    logic [DW-1:0] mem_lat = '0;
    logic          mem_rd_q = 1'b0;
    logic          mem_drive;

    initial for (int i = 0; i < 8; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (!nEnable && ReadWrite) begin
            mem_lat  <= mem[address[2:0]];
            mem_rd_q <= 1'b1;
        end else begin
            mem_rd_q <= 1'b0;
        end
    end

    always @(negedge clk) if (!nEnable && !ReadWrite) mem[address[2:0]] <= dataBus;

    assign mem_drive = mem_rd_q && !nEnable && !ReadWrite;
    assign dataBus   = mem_drive ? mem_lat : 'z;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_rd [$];
    int            exp_addr [$];
    int            exp_done [$];
    int            exp_err [$];
    logic [DW-1:0] wbuf [8];
    logic [DW-1:0] PAT_A5;
    logic [DW-1:0] PAT_12;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rdValid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rdData", rdData, exp_rd.pop_front());
        end
        if (done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done", 1, DW'(exp_done.pop_front()));
        end
        if (err) begin
            if (exp_err.size() == 0) chk("err_unexpected", 1, 0);
            else begin
                void'(exp_err.pop_front());
                chk("err_nEnable", nEnable, 1);
            end
        end
        if (!nEnable && (ReadWrite || dut.bus_oe)) begin
            if (exp_addr.size() == 0) chk("beat_unexpected", 1, 0);
            else chk("beat_address", address, DW'(exp_addr.pop_front()));
        end
        if (dut.bus_oe) begin
            chk("drive_with_ReadWrite", ReadWrite, 0);
            chk("bus_contention", mem_drive, 0);
        end
    end

    task automatic send_cmd(input logic w, input logic [3:0] a, input logic [2:0] l);
        int unsigned n;
        n = 0;
        cmdValid = 1'b1; cmdWrite = w; cmdAddr = a; cmdLen = l;
        while (!cmdReady && n < 100) begin @(posedge clk); #1; n++; end
        if (!cmdReady) chk("cmdReady_timeout", 0, 1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
    endtask

    task automatic write_beat(input logic [DW-1:0] d);
        int unsigned n;
        n = 0;
        wrData = d; wrValid = 1'b1;
        while (!wrReady && n < 100) begin @(posedge clk); #1; n++; end
        if (!wrReady) chk("wrReady_timeout", 0, 1);
        @(posedge clk); #1;
        wrValid = 1'b0;
    endtask

    task automatic do_store(input logic [3:0] a, input logic [2:0] l);
        for (int i = 0; i <= int'(l); i++) exp_addr.push_back((int'(a) + i) % 8);
        exp_done.push_back(1);
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) write_beat(wbuf[i]);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [2:0] l);
        for (int i = 0; i <= int'(l); i++) begin
            exp_addr.push_back((int'(a) + i) % 8);
            exp_rd.push_back(wbuf[i]);
        end
        exp_done.push_back(1);
        send_cmd(1'b0, a, l);
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((exp_done.size() != 0 || exp_rd.size() != 0 || exp_err.size() != 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        PAT_A5 = {16{16'hA5A5}};
        PAT_12 = {8{32'h1234_5678}};

        // Reset held 3 cycles.
        repeat (3) begin
            @(negedge clk);
            chk("rst_nEnable", nEnable, 1);
            chk("rst_ReadWrite", ReadWrite, 1);
            chk("rst_bus_oe", dut.bus_oe, 0);
        end
        @(posedge clk); #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_address", address, 0);
        chk("rst_rdData", rdData, 0);
        chk("rst_flags", {rdValid, done, err, wrReady}, 0);
        @(posedge clk); #1;

        // Single store then single load with latency checks.
        wbuf[0] = PAT_A5;
        do_store(4'd2, 3'd0);
        wait_idle();
        do_load(4'd2, 3'd0);
        @(negedge clk);
        chk("c1_rd_addr_phase", {nEnable, ReadWrite}, 2'b01);
        @(negedge clk);
        chk("c2_rd_data_phase", {nEnable, ReadWrite, rdValid}, 3'b000);
        @(negedge clk);
        chk("c3_rdValid_done", {rdValid, done}, 2'b11);
        wait_idle();

        // Wrapping burst 6,7,0,1.
        for (int i = 0; i < 4; i++) wbuf[i] = DW'(i + 1);
        do_store(4'd6, 3'd3);
        wait_idle();
        do_load(4'd6, 3'd3);
        wait_idle();

        // Out-of-range address.
        exp_err.push_back(1);
        send_cmd(1'b0, 4'd9, 3'd0);
        @(negedge clk);
        chk("bad_err_pulse", err, 1);
        @(negedge clk);
        chk("bad_after", {err, done, nEnable}, 3'b001);
        wait_idle();

        // Write-data stall: master must hold off the bus.
        exp_addr.push_back(4);
        exp_done.push_back(1);
        send_cmd(1'b1, 4'd4, 3'd0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_wait", {nEnable, wrReady, dut.bus_oe}, 3'b110);
        end
        @(posedge clk); #1;
        write_beat(PAT_12);
        wait_idle();
        wbuf[0] = PAT_12;
        do_load(4'd4, 3'd0);
        wait_idle();

        // Reset during a long load: beats 0..2 complete, beat 3 abandoned.
        exp_addr.push_back(0); exp_addr.push_back(1);
        exp_addr.push_back(2); exp_addr.push_back(3);
        exp_rd.push_back(DW'(3)); exp_rd.push_back(DW'(4)); exp_rd.push_back(PAT_A5);
        send_cmd(1'b0, 4'd0, 3'd7);
        repeat (6) @(posedge clk);
        #1;
        nReset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_bus", {nEnable, dut.bus_oe, done, rdValid}, 4'b1000);
        @(posedge clk); #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("midrst_cmdReady", cmdReady, 1);
        chk("midrst_queues", DW'(exp_rd.size() + exp_addr.size()), 0);
        @(posedge clk); #1;
        wbuf[0] = DW'(4);
        do_load(4'd1, 3'd0);
        wait_idle();

        chk("left_rd", DW'(exp_rd.size()), 0);
        chk("left_addr", DW'(exp_addr.size()), 0);
        chk("left_done", DW'(exp_done.size()), 0);
        chk("left_err", DW'(exp_err.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
